// File: rtl/shift_pla_inverse.sv
// Iterative inverse of the shift-only tanh PLA: y in (-1,1) -> x with y = PLA(x).
// Segment index is found by a serial leading-zero scan, one bit per clock.
module shift_pla_inverse #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned W_OUT = 8,
  parameter int unsigned OUT_I = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_IN-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out,
  output logic             sat
);

  localparam int unsigned F     = W_IN - 1;
  localparam int unsigned OUT_F = W_OUT - OUT_I;
  localparam int unsigned M_W   = OUT_I + F - 1;

  typedef enum logic [2:0] {IDLE, PREP, SCAN, BUILD, DONE} state_t;

  state_t             state_q, state_d;
  logic [W_IN-1:0]    in_q, in_d;
  logic               sign_q, sign_d;
  logic [F-1:0]       d_q, d_d;
  logic [OUT_I-1:0]   s_q, s_d;
  logic               satp_q, satp_d;
  logic [W_OUT-1:0]   out_q, out_d;
  logic               sat_q, sat_d;

  logic [F-1:0]       abs_c;
  logic               prep_sat_c;
  logic               s_last_c;
  logic [M_W-1:0]     m_c;
  logic [W_OUT-1:0]   mag_c;

  // |y| in F bits; -1 aliases to 0 here but is caught by prep_sat_c
  assign abs_c      = in_q[F] ? F'(~in_q + 1'b1) : in_q[F-1:0];
  assign prep_sat_c = (in_q == {1'b1, {F{1'b0}}}) || (abs_c == {F{1'b1}});
  assign s_last_c   = (s_q == {OUT_I{1'b1}});
  // Magnitude (s + r)/2 with F fractional bits; r comes from the scanned-out bits
  assign m_c        = {s_q, ~d_q[F-2:0]};

  generate
    if (OUT_F <= F) begin : g_trunc
      assign mag_c = W_OUT'(m_c >> (F - OUT_F));
    end else begin : g_pad
      assign mag_c = W_OUT'(m_c) << (OUT_F - F);
    end
  endgenerate

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = PREP;
      PREP:    state_d = prep_sat_c ? BUILD : SCAN;
      SCAN:    if (d_q[F-1] || s_last_c) state_d = BUILD;
      BUILD:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    in_d   = in_q;
    sign_d = sign_q;
    d_d    = d_q;
    s_d    = s_q;
    satp_d = satp_q;
    out_d  = out_q;
    sat_d  = sat_q;
    case (state_q)
      IDLE: if (in_valid) in_d = in;
      PREP: begin
        sign_d = in_q[F];
        satp_d = prep_sat_c;
        d_d    = ~abs_c;
        s_d    = '0;
      end
      SCAN: if (!d_q[F-1]) begin
        d_d = {d_q[F-2:0], 1'b0};
        s_d = OUT_I'(s_q + 1'b1);
        if (s_last_c) satp_d = 1'b1;
      end
      BUILD: begin
        sat_d = satp_q;
        if (satp_q)      out_d = sign_q ? {1'b1, {(W_OUT-1){1'b0}}} : {1'b0, {(W_OUT-1){1'b1}}};
        else if (sign_q) out_d = W_OUT'(~mag_c + 1'b1);
        else             out_d = mag_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_q   <= '0;
      sign_q <= 1'b0;
      d_q    <= '0;
      s_q    <= '0;
      satp_q <= 1'b0;
      out_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      in_q   <= in_d;
      sign_q <= sign_d;
      d_q    <= d_d;
      s_q    <= s_d;
      satp_q <= satp_d;
      out_q  <= out_d;
      sat_q  <= sat_d;
    end
  end

  assign out = out_q;
  assign sat = sat_q;

endmodule

// File: tb/tb_shift_pla_inverse.sv
// Bench for shift_pla_inverse: directed table, stall/reset sequences, full sweep
// against an arithmetic inverse model plus a forward-PLA bracket, and random traffic.
module tb_shift_pla_inverse;

  logic       clock;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       sat;

  int total = 0;
  int bad   = 0;

  shift_pla_inverse #(.W_IN(8), .W_OUT(8), .OUT_I(3)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .sat       (sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] y;
    logic [7:0] exp_out;
    logic       exp_sat;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Inverse from the segment rule: 1-|y| = 2^-s (1 - r/2), residual quantised to F bits
  function automatic void model(input logic [7:0] y, output logic [7:0] o,
                                output logic st, output int lat);
    int a, q, s, mag;
    a = y[7] ? (256 - int'(y)) : int'(y);
    if (a >= 127) begin
      st = 1'b1; o = y[7] ? 8'h80 : 8'h7F; lat = 2;
      return;
    end
    q = 127 - a;
    s = 0;
    while ((q << s) < 64) s++;
    mag = (s * 64 + 127 - (q << s)) / 4;
    o   = y[7] ? 8'(-mag) : 8'(mag);
    st  = 1'b0;
    lat = s + 3;
  endfunction

  function automatic real pla(input real x);
    real ax, r, p;
    int  s;
    ax = (x < 0.0) ? -x : x;
    s  = int'($floor(2.0 * ax));
    r  = 2.0 * ax - real'(s);
    p  = 1.0;
    for (int k = 0; k < s; k++) p = p / 2.0;
    return 1.0 - p * (1.0 - r / 2.0);
  endfunction

  task automatic reset_dut();
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle
  task automatic convert(input logic [7:0] y, input int hold, output logic [7:0] o,
                         output logic st, output int lat);
    din = y; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    o = dout; st = sat;
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout: out_valid never rose for in=0x%0h", y);
      reset_dut();
      return;
    end
    for (int k = 0; k < hold; k++) begin @(posedge clock); #1; end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_vs_model(input string tag, input logic [7:0] y, input int hold);
    logic [7:0] o, eo;
    logic       st, est;
    int         lat, elat;
    real        yv, xm, lo, hi;
    convert(y, hold, o, st, lat);
    model(y, eo, est, elat);
    check({tag, "_out"}, int'(o), int'(eo));
    check({tag, "_sat"}, int'(st), int'(est));
    check({tag, "_lat"}, lat, elat);
    if (!est) begin
      yv = real'(y[7] ? 256 - int'(y) : int'(y)) / 128.0;
      xm = real'($signed(o) < 0 ? -int'($signed(o)) : int'($signed(o))) / 32.0;
      lo = pla(xm);
      hi = pla(xm + 1.0 / 32.0);
      check({tag, "_fwd_bracket"},
            int'(lo <= yv + 1.0/128.0 + 1e-9 && hi >= yv - 1.0/128.0 - 1e-9), 1);
    end
  endtask

  initial begin
    logic [7:0] o;
    logic       st;
    int         lat;

    vecs[0] = '{8'h40, 8'h10, 1'b0, 4};
    vecs[1] = '{8'hC0, 8'hF0, 1'b0, 4};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 3};
    vecs[3] = '{8'h7F, 8'h7F, 1'b1, 2};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 2};
    vecs[5] = '{8'h01, 8'h00, 1'b0, 3};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 3};
    vecs[7] = '{8'h60, 8'h20, 1'b0, 5};
    vecs[8] = '{8'h7E, 8'h6F, 1'b0, 9};
    vecs[9] = '{8'h81, 8'h80, 1'b1, 2};

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 8'h00;
    repeat (2) @(posedge clock); #1;
    check("rst_out", int'(dout), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sat", int'(sat), 0);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].y, 0, o, st, lat);
      check($sformatf("vec%0d_out", i), int'(o), int'(vecs[i].exp_out));
      check($sformatf("vec%0d_sat", i), int'(st), int'(vecs[i].exp_sat));
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Hold the result for 10 cycles while a new word is offered
    din = 8'h60; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("stall_lat", lat, 5);
    din = 8'h40; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      check("stall_out", int'(dout), 8'h20);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("stall_drop_valid", int'(out_valid), 0);
    check("stall_back_idle", int'(in_ready), 1);
    convert(8'h00, 0, o, st, lat);
    check("post_stall_out", int'(o), 0);
    check("post_stall_lat", lat, 3);

    // Reset during the scan of a long-latency word, with a saturated result still held
    convert(8'h7F, 0, o, st, lat);
    din = 8'h7E; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    resetn = 1'b0;
    #1;
    check("midrst_out", int'(dout), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_sat", int'(sat), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    check("midrst_in_ready", int'(in_ready), 1);
    convert(8'h40, 0, o, st, lat);
    check("after_rst_out", int'(o), 8'h10);
    check("after_rst_sat", int'(st), 0);
    check("after_rst_lat", lat, 4);

    for (int v = 0; v < 256; v++) check_vs_model($sformatf("sweep%0h", v), 8'(v), 0);

    for (int i = 0; i < 150; i++)
      check_vs_model("rand", 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
